bob_line_scheduler: RTL and testbench
=====================================

BOB_LINE_SCHEDULER -- requirements
Module: bob_line_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width; matches the line FIFO data width.
REQ-002 SHALL have parameter LEN_W, default 11: line-length width; internal line RAM depth is 2^LEN_W.
REQ-003 SHALL have parameter FILL_VALUE, default 0: pixel value substituted on FIFO underflow.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all logic on rising edge; same domain as the FIFO read side.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 line_start  in  1  one-cycle pulse requesting output of one line.
REQ-008 cfg_line_len  in  LEN_W  pixels per line; sampled only on an accepted line_start.
REQ-009 cfg_double  in  1  BOB line-doubling enable; sampled only on an accepted line_start.
REQ-010 fifo_rd_en  out  1  read strobe to the line FIFO.
REQ-011 fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
REQ-012 fifo_rd_empty  in  1  FIFO empty flag.
REQ-013 pix_valid / pix_data  out  1 / DATA_WIDTH  output pixel strobe and value.
REQ-014 line_done  out  1  one-cycle pulse marking the end of a line.
REQ-015 busy  out  1  high while a line is in progress.
REQ-016 underflow  out  1  sticky flag set on any underflow.
REQ-017 underflow_cnt  out  16  saturating count of underflowed pixels.
REQ-018 start_err  out  1  sticky flag set when line_start arrives while busy.
REQ-019 clear_status  in  1  clears underflow, underflow_cnt and start_err.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH and REPLAY, plus an internal replay_pending bit.
REQ-021 In IDLE, line_start SHALL go to REPLAY if cfg_double=1 and replay_pending=1; otherwise it SHALL go to FETCH, and replay_pending SHALL clear.
REQ-022 For a line of length N, index k SHALL be issued in cycle k after line_start (k=0..N-1), with pix_valid high in cycles k+1 (1..N).
REQ-023 line_done SHALL pulse together with the Nth pix_valid, and the FSM SHALL return to IDLE in the same cycle.
REQ-024 busy SHALL be high from cycle 1 through cycle N inclusive.
REQ-025 In FETCH, fifo_rd_en SHALL equal (index active AND NOT fifo_rd_empty), and pix_data SHALL be fifo_rd_data.
REQ-026 If fifo_rd_empty is high at an issue cycle, the scheduler SHALL NOT assert fifo_rd_en, SHALL still output pix_valid with pix_data=FILL_VALUE, and SHALL set underflow and increment underflow_cnt; the index still advances (fixed video timing).
REQ-027 When cfg_double=1, FETCH SHALL write each output pixel, including fill pixels, to line RAM at its index, store N, and set replay_pending at line_done.
REQ-028 REPLAY SHALL read line RAM with the same timing as FETCH (1-cycle latency), use the stored N, never assert fifo_rd_en, and clear replay_pending at line_done.
REQ-029 cfg_line_len=0 SHALL produce no pixels, with line_done pulsed in cycle 1 and busy low throughout.
REQ-030 line_start while busy SHALL be ignored and SHALL set start_err; line_start coincident with line_done SHALL likewise be ignored.
REQ-031 underflow_cnt SHALL saturate at 0xFFFF.
REQ-032 clear_status coincident with an underflow event SHALL leave underflow=1 and underflow_cnt=1.

Reset
REQ-033 Reset SHALL force state IDLE, replay_pending=0, fifo_rd_en=0, pix_valid=0, pix_data=0, line_done=0, busy=0, underflow=0, underflow_cnt=0 and start_err=0.
REQ-034 Reset mid-line SHALL abort the line with no line_done, and fifo_rd_en SHALL be 0 in the first cycle after reset deasserts.
REQ-035 Line RAM contents SHALL NOT be reset; replay_pending=0 guarantees they are never replayed stale.

Structure
REQ-036 A shared package/header SHALL hold the FSM state encodings and the default DATA_WIDTH and LEN_W constants.
REQ-037 Line storage SHALL be one sub-module, bob_line_ram: single-port, synchronous write, registered read, depth 2^LEN_W.
REQ-038 The FSM, index counter and status counters SHALL live in bob_line_scheduler.

Verification
REQ-039 Bench SHALL cover: FIFO preloaded 0x01..0x10, len=16, double=0 -> fifo_rd_en cycles 0-15, pix 0x01..0x10 in cycles 1-16, line_done cycle 16, no underflow.
REQ-040 Bench SHALL cover: double=1, len=4, FIFO 0xA0..0xA3, two line_starts -> second line outputs 0xA0..0xA3 with zero FIFO reads, replay_pending cleared.
REQ-041 Bench SHALL cover: len=8 with only 5 words queued -> pixels 6-8 = FILL_VALUE, underflow=1, underflow_cnt=3, line_done still in cycle 8.
REQ-042 Bench SHALL cover: line_start in cycle 3 of a len=8 line -> ignored, start_err=1, line timing unchanged; clear_status -> start_err=0.
REQ-043 Bench SHALL cover: reset asserted in cycle 5 of a len=16 FETCH -> next cycle IDLE, busy=0, no line_done; a new line then starts cleanly at index 0.
REQ-044 Bench SHALL cover: len=0 -> line_done in cycle 1, no pix_valid, no fifo_rd_en; underflow_cnt preset to 0xFFFF plus one more underflow -> stays 0xFFFF.

Source files
------------

// File: rtl/bob_line_scheduler_pkg.sv
// Shared constants and FSM encoding for the BOB line scheduler.
package bob_line_scheduler_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_LEN_W      = 11;
    localparam int unsigned STAT_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_REPLAY = 2'd2
    } sched_state_e;

endpackage

// File: rtl/bob_line_ram.sv
// Single-port line store: synchronous write, registered read.
module bob_line_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LEN_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** LEN_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bob_line_scheduler.sv
// Emits one video line per line_start from the line FIFO, or replays the
// previously stored line when BOB doubling is enabled.
module bob_line_scheduler
    import bob_line_scheduler_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           LEN_W      = DEF_LEN_W,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [LEN_W-1:0]      cfg_line_len,
    input  logic                  cfg_double,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  line_done,
    output logic                  busy,
    output logic                  underflow,
    output logic [STAT_CNT_W-1:0] underflow_cnt,
    output logic                  start_err,
    input  logic                  clear_status
);

    sched_state_e state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d, stored_len_q;
    logic             dbl_q, replay_pending_q;

    logic             start_acc_c, start_ign_c, issue_c, last_c;
    logic             replay_mode_c, dbl_c, fetch_issue_c, underflow_ev_c;
    logic [LEN_W-1:0] line_len_c, issue_idx_c;

    logic             fill_q, from_ram_q, ram_we_q;
    logic [LEN_W-1:0] wr_idx_q, ram_addr_c;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  underflow_d, start_err_d;
    logic [STAT_CNT_W-1:0] underflow_cnt_d;

    // Issue one index per cycle; cycle 0 issues straight out of IDLE.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        issue_c       = 1'b0;
        replay_mode_c = (state_q == ST_REPLAY);
        dbl_c         = dbl_q;
        line_len_c    = len_q;
        issue_idx_c   = idx_q;
        start_acc_c   = line_start && (state_q == ST_IDLE) && !busy && !line_done;
        start_ign_c   = line_start && !start_acc_c;
        case (state_q)
            ST_IDLE: begin
                if (start_acc_c) begin
                    replay_mode_c = cfg_double && replay_pending_q;
                    dbl_c         = cfg_double;
                    line_len_c    = replay_mode_c ? stored_len_q : cfg_line_len;
                    issue_idx_c   = '0;
                    issue_c       = (line_len_c != '0);
                    len_d         = line_len_c;
                    idx_d         = LEN_W'(1);
                    if (issue_c && (line_len_c != LEN_W'(1))) begin
                        state_d = replay_mode_c ? ST_REPLAY : ST_FETCH;
                    end
                end
            end
            ST_FETCH, ST_REPLAY: begin
                issue_c = 1'b1;
                idx_d   = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        last_c         = issue_c && (issue_idx_c == line_len_c - LEN_W'(1));
        fetch_issue_c  = issue_c && !replay_mode_c;
        underflow_ev_c = fetch_issue_c && fifo_rd_empty;
    end

    // Clear first so an underflow in the same cycle still counts once.
    always_comb begin
        underflow_d     = underflow;
        underflow_cnt_d = underflow_cnt;
        start_err_d     = start_err;
        if (clear_status) begin
            underflow_d     = 1'b0;
            underflow_cnt_d = '0;
            start_err_d     = 1'b0;
        end
        if (underflow_ev_c) begin
            underflow_d = 1'b1;
            if (underflow_cnt_d != '1) begin
                underflow_cnt_d = underflow_cnt_d + STAT_CNT_W'(1);
            end
        end
        if (start_ign_c) begin
            start_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            len_q            <= '0;
            stored_len_q     <= '0;
            dbl_q            <= 1'b0;
            replay_pending_q <= 1'b0;
            pix_valid        <= 1'b0;
            busy             <= 1'b0;
            line_done        <= 1'b0;
            fill_q           <= 1'b0;
            from_ram_q       <= 1'b0;
            ram_we_q         <= 1'b0;
            wr_idx_q         <= '0;
            underflow        <= 1'b0;
            underflow_cnt    <= '0;
            start_err        <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            if (start_acc_c) begin
                dbl_q <= dbl_c;
            end
            if (start_acc_c && !replay_mode_c) begin
                replay_pending_q <= 1'b0;
                if (cfg_double) begin
                    stored_len_q <= cfg_line_len;
                end
            end
            if (last_c) begin
                replay_pending_q <= dbl_c && !replay_mode_c;
            end
            pix_valid     <= issue_c;
            busy          <= issue_c;
            line_done     <= last_c || (start_acc_c && !issue_c);
            fill_q        <= underflow_ev_c;
            from_ram_q    <= issue_c && replay_mode_c;
            ram_we_q      <= fetch_issue_c && dbl_c;
            wr_idx_q      <= issue_idx_c;
            underflow     <= underflow_d;
            underflow_cnt <= underflow_cnt_d;
            start_err     <= start_err_d;
        end
    end

    // FIFO and RAM both return data one cycle after the issue.
    assign fifo_rd_en = fetch_issue_c && !fifo_rd_empty && !reset;
    assign pix_data   = !pix_valid ? '0 :
                        from_ram_q ? ram_rdata :
                        fill_q     ? FILL_VALUE : fifo_rd_data;
    assign ram_addr_c = ram_we_q ? wr_idx_q : issue_idx_c;

    bob_line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W      (LEN_W)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we_q),
        .addr  (ram_addr_c),
        .wdata (pix_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_bob_line_scheduler.sv
// Directed bench for bob_line_scheduler with a simple FIFO model.
module tb_bob_line_scheduler;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 11;
    localparam logic [DW-1:0] FILL = 8'hEE;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          line_start = 1'b0;
    logic [LW-1:0] cfg_line_len = '0;
    logic          cfg_double = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          line_done;
    logic          busy;
    logic          underflow;
    logic [15:0]   underflow_cnt;
    logic          start_err;
    logic          clear_status = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fmem [256];
    int            fwr = 0;
    int            frd = 0;

    logic [63:0]   rd_mask, pv_mask, ld_mask, busy_mask;
    logic [DW-1:0] pix_q [$];
    int            frd_mark;

    bob_line_scheduler #(
        .DATA_WIDTH (DW),
        .LEN_W      (LW),
        .FILL_VALUE (FILL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .line_start    (line_start),
        .cfg_line_len  (cfg_line_len),
        .cfg_double    (cfg_double),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .line_done     (line_done),
        .busy          (busy),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .start_err     (start_err),
        .clear_status  (clear_status)
    );

    always #5 clk = ~clk;

    assign fifo_rd_empty = (fwr == frd);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fmem[frd];
            frd          <= frd + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fifo_push(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[fwr] = first + DW'(i);
            fwr = fwr + 1;
        end
    endtask

    // Cycle c is the window between negedge c and posedge c; c=0 carries line_start.
    task automatic run_line(input logic [LW-1:0] len, input logic dbl, input int ncyc,
                            input int start2_c, input int rst_c, input int clr_c);
        rd_mask = '0; pv_mask = '0; ld_mask = '0; busy_mask = '0;
        pix_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            line_start   = (c == 0) || (c == start2_c);
            cfg_line_len = len;
            cfg_double   = dbl;
            reset        = (c == rst_c);
            clear_status = (c == clr_c);
            #1;
            rd_mask[c]   = fifo_rd_en;
            pv_mask[c]   = pix_valid;
            ld_mask[c]   = line_done;
            busy_mask[c] = busy;
            if (pix_valid) pix_q.push_back(pix_data);
        end
        @(negedge clk);
        line_start = 1'b0; reset = 1'b0; clear_status = 1'b0;
        #1;
    endtask

    task automatic check_pix(input string tag, input logic [DW-1:0] first, input int n_inc, input int n_fill);
        logic [DW-1:0] exp;
        check({tag, "_count"}, 64'(pix_q.size()), 64'(n_inc + n_fill));
        for (int i = 0; i < pix_q.size() && i < n_inc + n_fill; i++) begin
            exp = (i < n_inc) ? first + DW'(i) : FILL;
            check($sformatf("%s_pix%0d", tag, i), 64'(pix_q[i]), 64'(exp));
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_status = 1'b1;
        @(negedge clk); clear_status = 1'b0;
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pix_valid", 64'(pix_valid), 64'd0);
        check("rst_pix_data",  64'(pix_data), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_line_done", 64'(line_done), 64'd0);
        check("rst_rd_en",     64'(fifo_rd_en), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_ucnt",      64'(underflow_cnt), 64'd0);
        check("rst_start_err", 64'(start_err), 64'd0);

        // Plain 16-pixel line
        fifo_push(8'h01, 16);
        run_line(11'd16, 1'b0, 20, -1, -1, -1);
        check("l16_rd_en", rd_mask, 64'h0000_FFFF);
        check("l16_valid", pv_mask, 64'h0001_FFFE);
        check("l16_done",  ld_mask, 64'h0001_0000);
        check("l16_busy",  busy_mask, 64'h0001_FFFE);
        check_pix("l16", 8'h01, 16, 0);
        check("l16_underflow", 64'(underflow), 64'd0);

        // Doubled line then replay from RAM
        fifo_push(8'hA0, 4);
        run_line(11'd4, 1'b1, 8, -1, -1, -1);
        check("dbl_rd_en", rd_mask, 64'h0F);
        check("dbl_valid", pv_mask, 64'h1E);
        check("dbl_done",  ld_mask, 64'h10);
        check_pix("dbl", 8'hA0, 4, 0);
        check("dbl_pending", 64'(dut.replay_pending_q), 64'd1);
        frd_mark = frd;
        run_line(11'd4, 1'b1, 8, -1, -1, -1);
        check("rep_rd_en", rd_mask, 64'h00);
        check("rep_valid", pv_mask, 64'h1E);
        check("rep_done",  ld_mask, 64'h10);
        check_pix("rep", 8'hA0, 4, 0);
        check("rep_fifo_reads", 64'(frd - frd_mark), 64'd0);
        check("rep_pending", 64'(dut.replay_pending_q), 64'd0);

        // Underflow: 8-pixel line, 5 words queued
        fifo_push(8'h31, 5);
        run_line(11'd8, 1'b0, 11, -1, -1, -1);
        check("uf_rd_en", rd_mask, 64'h01F);
        check("uf_valid", pv_mask, 64'h1FE);
        check("uf_done",  ld_mask, 64'h100);
        check_pix("uf", 8'h31, 5, 3);
        check("uf_flag", 64'(underflow), 64'd1);
        check("uf_cnt",  64'(underflow_cnt), 64'd3);
        pulse_clear();
        check("uf_clr_flag", 64'(underflow), 64'd0);
        check("uf_clr_cnt",  64'(underflow_cnt), 64'd0);

        // Start while busy is ignored
        fifo_push(8'h41, 8);
        run_line(11'd8, 1'b0, 11, 3, -1, -1);
        check("se_rd_en", rd_mask, 64'h0FF);
        check("se_valid", pv_mask, 64'h1FE);
        check("se_done",  ld_mask, 64'h100);
        check_pix("se", 8'h41, 8, 0);
        check("se_flag", 64'(start_err), 64'd1);
        pulse_clear();
        check("se_clr", 64'(start_err), 64'd0);

        // Reset mid-line, then clean restart
        fifo_push(8'h51, 8);
        run_line(11'd16, 1'b0, 10, -1, 5, -1);
        check("rs_rd_en", rd_mask, 64'h01F);
        check("rs_valid", pv_mask, 64'h03E);
        check("rs_busy",  busy_mask, 64'h03E);
        check("rs_done",  ld_mask, 64'h000);
        check_pix("rs", 8'h51, 5, 0);
        run_line(11'd3, 1'b1, 6, -1, -1, -1);
        check("rs2_rd_en", rd_mask, 64'h07);
        check("rs2_valid", pv_mask, 64'h0E);
        check("rs2_done",  ld_mask, 64'h08);
        check_pix("rs2", 8'h56, 3, 0);
        run_line(11'd3, 1'b1, 6, -1, -1, -1);
        check("rs3_rd_en", rd_mask, 64'h00);
        check("rs3_done",  ld_mask, 64'h08);
        check_pix("rs3", 8'h56, 3, 0);

        // Zero-length line
        run_line(11'd0, 1'b0, 4, -1, -1, -1);
        check("z_rd_en", rd_mask, 64'h0);
        check("z_valid", pv_mask, 64'h0);
        check("z_done",  ld_mask, 64'h2);
        check("z_busy",  busy_mask, 64'h0);

        // Counter saturation
        @(negedge clk);
        force dut.underflow_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.underflow_cnt;
        #1;
        check("sat_preset", 64'(underflow_cnt), 64'hFFFF);
        run_line(11'd1, 1'b0, 3, -1, -1, -1);
        check("sat_rd_en", rd_mask, 64'h0);
        check("sat_done",  ld_mask, 64'h2);
        check_pix("sat", 8'h00, 0, 1);
        check("sat_cnt",  64'(underflow_cnt), 64'hFFFF);

        // Clear coincident with an underflow
        run_line(11'd1, 1'b0, 3, -1, -1, 0);
        check("clrev_flag", 64'(underflow), 64'd1);
        check("clrev_cnt",  64'(underflow_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
